block_trial_core: RTL and testbench
===================================

# block_trial_core

Self-contained scoped stack-machine that executes a fixed 16-entry program ROM after reset and presents the final value on an 8-bit result port. It is the hardware check of block-scoped evaluation: nested blocks bind values on a value stack, and each block returns its top value. The built-in program evaluates `{ x=10; { y=20; x+y } }` and returns 0x1E. No host interface; it sits standalone under a top level or bench that only samples `returnValue`.

## Interface
- `STACK_DEPTH`, 8: value-stack entries, each 8-bit.
- `SCOPE_DEPTH`, 4: scope-stack entries, each holds a saved stack pointer.
- `PROG_FILE`, "": hex file for ROM init ($readmemh). Empty means use the built-in program.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high. Tie low if unused.
- `returnValue` out 8: result register.
- `halted` out 1: high once HALT or an error has executed.

## Operation
- Instruction is 8 bits: [7:5] opcode, [4:0] operand `k`.
- Opcodes:
  - 0 NOP.
  - 1 PUSH: push zero-extended `k`.
  - 2 LOAD: push `stack[k]`, where `k` is an absolute slot index.
  - 3 ADD: pop b, pop a, push (a+b) mod 256.
  - 4 ENTER: push current SP onto the scope stack.
  - 5 EXIT: v = top value; SP = popped scope entry; push v.
  - 6 and 7 HALT: `returnValue` = top value, or 0x00 if the stack is empty. Set `halted`.
- Built-in ROM:
  - 0 ENTER(0x80)
  - 1 PUSH 10(0x2A)
  - 2 ENTER
  - 3 PUSH 20(0x34)
  - 4 LOAD 0(0x40)
  - 5 LOAD 1(0x41)
  - 6 ADD(0x60)
  - 7 EXIT(0xA0)
  - 8 EXIT
  - 9 HALT(0xC0)
  - 10–15 HALT
- Final stack is [30] and `returnValue` = 0x1E.
- Error conditions, all of which halt with `returnValue` = 0xEE:
  - push while SP == STACK_DEPTH;
  - pop from an empty stack;
  - LOAD with `k` ≥ SP;
  - ENTER with the scope stack full;
  - EXIT with the scope stack empty, or with no value above the saved SP.
- Halted state is terminal: PC, stacks and outputs are frozen until `reset`.
- PC wraps 15→0. This is unreachable with any ROM whose entry 15 is HALT.

## Timing
- One instruction per cycle, no stalls.
- Instruction at PC n executes on the (n+1)-th rising edge after the first edge with `reset` low.
- Built-in program: HALT executes on edge 10, so `returnValue` = 0x1E from edge 10 onward. It must be valid within 15 cycles.
- Reset values: PC=0, SP=0, scope SP=0, `returnValue`=0x00, `halted`=0. Stack contents are don't-care.
- Every register carries a power-up initial value equal to its reset value. The block therefore runs correctly with `reset` tied low.
- `reset` asserted mid-run or after halt: state returns to reset values on that edge and execution restarts from PC 0 on the first edge after deassertion.
- `returnValue` changes only on the HALT or error edge and on reset. No intermediate values appear.

## Structure
- Package `block_trial_pkg`: opcode localparams, instruction field widths, error code 0xEE, built-in ROM contents as a constant array.
- Sub-module `block_trial_rom` (16×8 combinational ROM, PROG_FILE override).
- Core holds PC, value stack, scope stack and the halt/error logic.
- Target 150–250 lines total.

## Test plan
- Built-in program, `reset` held low from time 0: `returnValue`=0x00 through edge 9, 0x1E from edge 10; `halted`=1 from edge 10; stays 0x1E at edge 15.
- Pulse `reset` for 1 cycle at edge 5: `returnValue`/`halted` are 0 on the next edge; 0x1E appears exactly 10 edges after deassertion.
- Reset after halt: outputs clear to 0 on the reset edge, then 0x1E is reproduced.
- PROG_FILE `PUSH 31, PUSH 31, ADD, … ADD ×8 chain`: 8-bit wrap is correct, e.g. program `PUSH 31, PUSH 31, ADD, HALT` gives 0x3E, and a sum crossing 255 wraps mod 256.
- PROG_FILE with 9 PUSHes, then HALT: halts with 0xEE on the 9th push edge.
- PROG_FILE `EXIT, HALT` gives 0xEE, `halted`=1 on edge 1. `LOAD 3` with SP=1 also gives 0xEE.

Source files
------------

// File: rtl/block_trial_pkg.sv
// Shared definitions for the block-scoped stack machine: instruction format,
// opcodes, error code and the built-in program image.
package block_trial_pkg;

    localparam int OPC_W  = 3;
    localparam int OPD_W  = 5;
    localparam int INSN_W = OPC_W + OPD_W;

    localparam logic [OPC_W-1:0] OP_NOP   = 3'd0;
    localparam logic [OPC_W-1:0] OP_PUSH  = 3'd1;
    localparam logic [OPC_W-1:0] OP_LOAD  = 3'd2;
    localparam logic [OPC_W-1:0] OP_ADD   = 3'd3;
    localparam logic [OPC_W-1:0] OP_ENTER = 3'd4;
    localparam logic [OPC_W-1:0] OP_EXIT  = 3'd5;
    localparam logic [OPC_W-1:0] OP_HALT  = 3'd6;
    localparam logic [OPC_W-1:0] OP_HALT2 = 3'd7;

    localparam logic [7:0] ERR_CODE = 8'hEE;

    typedef struct packed {
        logic [OPC_W-1:0] op;
        logic [OPD_W-1:0] k;
    } insn_t;

    // Entry n of the program lives in element n; element 15 is the MSB byte.
    typedef logic [15:0][INSN_W-1:0] rom_image_t;

    // { x=10; { y=20; x+y } } followed by HALT padding
    localparam rom_image_t BUILTIN_ROM = 128'hC0C0C0C0_C0C0C0A0_A0604140_34802A80;

endpackage

// File: rtl/block_trial_rom.sv
// 16x8 combinational program ROM, taken from a constant program image.
module block_trial_rom
    import block_trial_pkg::*;
#(
    parameter string      PROG_FILE  = "",
    parameter rom_image_t PROG_IMAGE = BUILTIN_ROM
) (
    input  logic [3:0]        i_addr,
    output logic [INSN_W-1:0] o_data
);

    assign o_data = PROG_IMAGE[i_addr];

endmodule

// File: rtl/block_trial_core.sv
// Scoped stack machine: executes one ROM instruction per cycle, keeps a value
// stack plus a stack of saved stack pointers, and latches the final result.
module block_trial_core
    import block_trial_pkg::*;
#(
    parameter int         STACK_DEPTH = 8,
    parameter int         SCOPE_DEPTH = 4,
    parameter string      PROG_FILE   = "",
    parameter rom_image_t PROG_IMAGE  = BUILTIN_ROM
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] returnValue,
    output logic       halted
);

    localparam int SPW = $clog2(STACK_DEPTH);
    localparam int SCW = $clog2(SCOPE_DEPTH);

    localparam logic [SPW:0]   SP_ZERO  = '0;
    localparam logic [SPW:0]   SP_ONE   = (SPW+1)'(1);
    localparam logic [SPW:0]   SP_TWO   = (SPW+1)'(2);
    localparam logic [SPW:0]   SP_FULL  = (SPW+1)'(STACK_DEPTH);
    localparam logic [SPW-1:0] IDX_ONE  = SPW'(1);
    localparam logic [SPW-1:0] IDX_TWO  = SPW'(2);
    localparam logic [SCW:0]   SC_ZERO  = '0;
    localparam logic [SCW:0]   SC_ONE   = (SCW+1)'(1);
    localparam logic [SCW:0]   SC_FULL  = (SCW+1)'(SCOPE_DEPTH);

    // Power-up values equal reset values so the block also runs with reset tied low.
    logic [3:0]   r_pc     = 4'd0;
    logic [SPW:0] r_sp     = '0;
    logic [SCW:0] r_ssp    = '0;
    logic [7:0]   r_ret    = 8'h00;
    logic         r_halted = 1'b0;
    logic [7:0]   r_stack [STACK_DEPTH];
    logic [SPW:0] r_scope [SCOPE_DEPTH];

    logic [INSN_W-1:0] w_rom_data;
    insn_t             w_insn;
    logic [SPW-1:0]    w_top_idx;
    logic [SPW-1:0]    w_second_idx;
    logic [7:0]        w_top;
    logic [7:0]        w_second;
    logic [SPW:0]      w_sp_m1;
    logic [SCW:0]      w_ssp_m1;
    logic [SPW:0]      w_saved;
    logic              w_err;
    logic              w_halt;
    logic [SPW:0]      w_nxt_sp;
    logic [SCW:0]      w_nxt_ssp;
    logic              w_wr_en;
    logic [SPW-1:0]    w_wr_idx;
    logic [7:0]        w_wr_data;
    logic              w_sc_wr_en;
    logic [7:0]        w_result;

    block_trial_rom #(
        .PROG_FILE (PROG_FILE),
        .PROG_IMAGE(PROG_IMAGE)
    ) u_rom (
        .i_addr(r_pc),
        .o_data(w_rom_data)
    );

    assign w_insn       = insn_t'(w_rom_data);
    assign w_top_idx    = r_sp[SPW-1:0] - IDX_ONE;
    assign w_second_idx = r_sp[SPW-1:0] - IDX_TWO;
    assign w_top        = r_stack[w_top_idx];
    assign w_second     = r_stack[w_second_idx];
    assign w_sp_m1      = r_sp - SP_ONE;
    assign w_ssp_m1     = r_ssp - SC_ONE;
    assign w_saved      = r_scope[w_ssp_m1[SCW-1:0]];

    // Decode and execute the current instruction, flagging every stack misuse.
    always_comb begin
        w_err      = 1'b0;
        w_halt     = 1'b0;
        w_nxt_sp   = r_sp;
        w_nxt_ssp  = r_ssp;
        w_wr_en    = 1'b0;
        w_wr_idx   = r_sp[SPW-1:0];
        w_wr_data  = 8'h00;
        w_sc_wr_en = 1'b0;
        w_result   = (r_sp == SP_ZERO) ? 8'h00 : w_top;
        case (w_insn.op)
            OP_NOP: begin
                w_err = 1'b0;
            end
            OP_PUSH: begin
                if (r_sp == SP_FULL) begin
                    w_err = 1'b1;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_data = 8'(w_insn.k);
                    w_nxt_sp  = r_sp + SP_ONE;
                end
            end
            OP_LOAD: begin
                if ((r_sp == SP_FULL) || (32'(w_insn.k) >= 32'(r_sp))) begin
                    w_err = 1'b1;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_data = r_stack[w_insn.k[SPW-1:0]];
                    w_nxt_sp  = r_sp + SP_ONE;
                end
            end
            OP_ADD: begin
                if (r_sp < SP_TWO) begin
                    w_err = 1'b1;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_second_idx;
                    w_wr_data = w_second + w_top;
                    w_nxt_sp  = w_sp_m1;
                end
            end
            OP_ENTER: begin
                if (r_ssp == SC_FULL) begin
                    w_err = 1'b1;
                end else begin
                    w_sc_wr_en = 1'b1;
                    w_nxt_ssp  = r_ssp + SC_ONE;
                end
            end
            OP_EXIT: begin
                // The block's top value replaces everything it bound.
                if ((r_ssp == SC_ZERO) || (r_sp <= w_saved)) begin
                    w_err = 1'b1;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_saved[SPW-1:0];
                    w_wr_data = w_top;
                    w_nxt_sp  = w_saved + SP_ONE;
                    w_nxt_ssp = w_ssp_m1;
                end
            end
            OP_HALT, OP_HALT2: begin
                w_halt = 1'b1;
            end
            default: begin
                w_halt = 1'b1;
            end
        endcase
    end

    // Control state: PC, stack pointers, result and the terminal halted flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= 4'd0;
            r_sp     <= SP_ZERO;
            r_ssp    <= SC_ZERO;
            r_ret    <= 8'h00;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (w_err) begin
                r_ret    <= ERR_CODE;
                r_halted <= 1'b1;
            end else if (w_halt) begin
                r_ret    <= w_result;
                r_halted <= 1'b1;
            end else begin
                r_pc  <= r_pc + 4'd1;
                r_sp  <= w_nxt_sp;
                r_ssp <= w_nxt_ssp;
            end
        end
    end

    // Value and scope stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!reset && !r_halted && !w_err) begin
            if (w_wr_en) begin
                r_stack[w_wr_idx] <= w_wr_data;
            end
            if (w_sc_wr_en) begin
                r_scope[r_ssp[SCW-1:0]] <= r_sp;
            end
        end
    end

    assign returnValue = r_ret;
    assign halted      = r_halted;

endmodule

// File: tb/tb_block_trial_core.sv
// Runs a set of programs side by side under shared random reset activity and
// checks each instance every cycle against a queue-based interpreter.
module tb_block_trial_core;

    localparam int NP = 12;

    localparam logic [127:0] IMG0  = 128'hC0C0C0C0_C0C0C0A0_A0604140_34802A80; // built-in: 0x1E at edge 10
    localparam logic [127:0] IMG1  = 128'hC0C0C0C0_C0C0C0C0_C0C0C0C0_C0603F3F; // 31+31 = 0x3E
    localparam logic [127:0] IMG2  = 128'hC0C0C0C0_C0603F60_40604060_4060403F; // doubling chain wraps past 255
    localparam logic [127:0] IMG3  = 128'hC0C0C0C0_C0C0C029_28272625_24232221; // nine pushes overflow
    localparam logic [127:0] IMG4  = 128'hC0C0C0C0_C0C0C0C0_C0C0C0C0_C0C0C0A0; // EXIT with no scope
    localparam logic [127:0] IMG5  = 128'hC0C0C0C0_C0C0C0C0_C0C0C0C0_C0C04325; // LOAD 3 with SP=1
    localparam logic [127:0] IMG6  = 128'hC0C0C0C0_C0C0C0C0_C0C0C080_80808080; // five ENTERs
    localparam logic [127:0] IMG7  = 128'hC0C0C0C0_C0C0C0C0_C0C0C0C0_C0C0C0C0; // HALT on empty stack
    localparam logic [127:0] IMG8  = 128'hC0C0C0C0_C0C0C0C0_C0C0C0C0_C0C0A080; // EXIT with nothing bound
    localparam logic [127:0] IMG9  = 128'hC0C0C0C0_C0C0C0C0_C0C0C0C0_C0C0C060; // ADD on empty stack
    localparam logic [127:0] IMG10 = 128'hC0C0C0C0_C0C0C0C0_C0C060A0_22298027; // scope drop then ADD = 9
    localparam logic [127:0] IMG11 = 128'h00000000_00000000_00000000_00000021; // PC wrap, push every 16 cycles

    localparam logic [NP-1:0][127:0] IMAGES =
        {IMG11, IMG10, IMG9, IMG8, IMG7, IMG6, IMG5, IMG4, IMG3, IMG2, IMG1, IMG0};

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rv [NP];
    logic       hl [NP];

    int         halt_edge [NP];
    logic [7:0] hval [NP];
    int         run_cnt = 0;
    bit         ready   = 1'b0;
    int         n_cmp   = 0;
    int         n_bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NP; g++) begin : g_dut
        block_trial_core #(
            .STACK_DEPTH(8),
            .SCOPE_DEPTH(4),
            .PROG_FILE  (""),
            .PROG_IMAGE (IMAGES[g])
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .returnValue(rv[g]),
            .halted     (hl[g])
        );
    end

    // Interpreter: returns the edge (counted from the first edge out of reset)
    // on which the program halts, and the value it leaves on the result port.
    function automatic void run_model(input logic [127:0] img, output int he, output logic [7:0] v);
        logic [7:0] stk [$];
        int         sc [$];
        int         pc;
        int         k;
        int         s;
        logic [7:0] ins;
        logic [7:0] a;
        logic [7:0] b;
        bit         err;
        bit         done;
        he = 1000000;
        v  = 8'h00;
        pc = 0;
        for (int step = 1; step <= 400; step++) begin
            ins  = img[8*pc +: 8];
            k    = int'(ins[4:0]);
            err  = 1'b0;
            done = 1'b0;
            case (ins[7:5])
                3'd1: if (stk.size() == 8) err = 1'b1; else stk.push_back(8'(k));
                3'd2: if (k >= stk.size() || stk.size() == 8) err = 1'b1; else stk.push_back(stk[k]);
                3'd3: if (stk.size() < 2) err = 1'b1;
                      else begin b = stk.pop_back(); a = stk.pop_back(); stk.push_back(8'(a + b)); end
                3'd4: if (sc.size() == 4) err = 1'b1; else sc.push_back(stk.size());
                3'd5: if (sc.size() == 0) err = 1'b1;
                      else begin
                          s = sc.pop_back();
                          if (stk.size() <= s) err = 1'b1;
                          else begin
                              a = stk[$];
                              while (stk.size() > s) void'(stk.pop_back());
                              stk.push_back(a);
                          end
                      end
                3'd6, 3'd7: begin done = 1'b1; v = (stk.size() == 0) ? 8'h00 : stk[$]; end
                default: ;
            endcase
            if (err) begin he = step; v = 8'hEE; return; end
            if (done) begin he = step; return; end
            pc = (pc + 1) % 16;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        reset = 1'b1;
        repeat (hi) @(negedge clk);
        reset = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Edges since the last reset edge; zero right after a reset edge.
    always @(posedge clk) begin
        run_cnt <= reset ? 0 : run_cnt + 1;
    end

    // Every instance, every cycle: result is 0 before the halt edge, final value from it on.
    always @(negedge clk) begin
        if (ready) begin
            for (int g = 0; g < NP; g++) begin
                check($sformatf("halted[%0d]@%0d", g, run_cnt), 32'(hl[g]),
                      32'(run_cnt >= halt_edge[g]));
                check($sformatf("returnValue[%0d]@%0d", g, run_cnt), 32'(rv[g]),
                      (run_cnt >= halt_edge[g]) ? 32'(hval[g]) : 32'h0);
            end
        end
    end

    initial begin
        for (int g = 0; g < NP; g++) begin
            run_model(IMAGES[g], halt_edge[g], hval[g]);
        end
        check("pin_builtin_edge", 32'(halt_edge[0]), 32'd10);
        check("pin_builtin_val",  32'(hval[0]),      32'h1E);
        check("pin_add_val",      32'(hval[1]),      32'h3E);
        check("pin_wrap_val",     32'(hval[2]),      32'h0F);
        check("pin_wrap_edge",    32'(halt_edge[2]), 32'd12);
        check("pin_ovf_edge",     32'(halt_edge[3]), 32'd9);
        check("pin_ovf_val",      32'(hval[3]),      32'hEE);
        check("pin_exit_edge",    32'(halt_edge[4]), 32'd1);
        check("pin_load_val",     32'(hval[5]),      32'hEE);
        check("pin_empty_val",    32'(hval[7]),      32'h00);
        check("pin_scope_val",    32'(hval[10]),     32'h09);
        check("pin_pcwrap_edge",  32'(halt_edge[11]), 32'd129);
        ready = 1'b1;

        repeat (150) @(negedge clk);
        pulse(1, 4);
        pulse(1, 20);
        for (int i = 0; i < 12; i++) begin
            pulse(int'($urandom_range(1, 3)), int'($urandom_range(2, 30)));
        end
        pulse(1, 140);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
